// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared defaults, state and request types for the register file write port controller
package regfile_ctrl_pkg;

    localparam int RF_XLEN    = 32;
    localparam int RF_AW      = 5;
    localparam int RF_NREG    = 32;
    localparam int RF_AGE_MAX = 4;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_ctrl_state_t;

    typedef struct packed {
        logic [RF_AW-1:0]   addr;
        logic [RF_XLEN-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/rf_clear_seq.sv
// rtl/rf_clear_seq.sv - walks x1..x(NREG-1) once after reset to zero the register file
module rf_clear_seq
    import regfile_ctrl_pkg::*;
#(
    parameter int AW   = RF_AW,
    parameter int NREG = RF_NREG
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          active,
    output logic          clear_we,
    output logic [AW-1:0] clear_addr,
    output logic          clear_last,
    output logic          clear_done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    logic [AW-1:0] clr_idx;

    // x0 is hardwired zero, so the walk starts at 1
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_idx    <= AW'(1);
            clear_done <= 1'b0;
        end else if (active) begin
            if (clear_last) begin
                clear_done <= 1'b1;
            end else begin
                clr_idx <= clr_idx + 1'b1;
            end
        end
    end

    assign clear_we   = active;
    assign clear_addr = clr_idx;
    assign clear_last = (clr_idx == LAST_IDX);

endmodule

// File: rtl/regfile_port_ctrl.sv
// rtl/regfile_port_ctrl.sv - register file write port controller: post-reset clear plus A/B writeback arbitration
module regfile_port_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int XLEN    = RF_XLEN,
    parameter int AW      = RF_AW,
    parameter int NREG    = RF_NREG,
    parameter int AGE_MAX = RF_AGE_MAX
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [AW-1:0]   a_addr,
    input  logic [XLEN-1:0] a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [AW-1:0]   b_addr,
    input  logic [XLEN-1:0] b_data,
    output logic            rf_we3,
    output logic [AW-1:0]   rf_a3,
    output logic [XLEN-1:0] rf_wd3,
    output logic            init_done
);

    localparam logic [3:0] AGE_LIM = 4'(AGE_MAX);

    rf_ctrl_state_t state, state_next;
    logic [3:0]     age;
    logic           force_b;
    logic           a_grant;
    logic           b_grant;
    logic           wr_en;
    rf_wr_t         a_req;
    rf_wr_t         b_req;
    rf_wr_t         sel_req;

    logic          clear_we;
    logic [AW-1:0] clear_addr;
    logic          clear_last;
    logic          clear_done;

    rf_clear_seq #(
        .AW   (AW),
        .NREG (NREG)
    ) u_clear_seq (
        .clk        (clk),
        .reset      (reset),
        .active     (state == CLEAR),
        .clear_we   (clear_we),
        .clear_addr (clear_addr),
        .clear_last (clear_last),
        .clear_done (clear_done)
    );

    assign a_req = '{addr: a_addr, data: a_data};
    assign b_req = '{addr: b_addr, data: b_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state == CLEAR && clear_last) begin
            state_next = RUN;
        end
    end

    // Readiness is shaped so that at most one requester can be granted per cycle
    always_comb begin
        force_b = 1'b0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (state == RUN) begin
            force_b = (age == AGE_LIM) && b_valid;
            a_ready = !force_b;
            b_ready = force_b || !a_valid;
        end
        a_grant = a_valid && a_ready;
        b_grant = b_valid && b_ready;
        sel_req = b_grant ? b_req : a_req;
        wr_en   = (a_grant || b_grant) && (sel_req.addr != '0);
    end

    always_ff @(posedge clk) begin
        if (reset || state != RUN || !b_valid || b_grant) begin
            age <= 4'd0;
        end else if (age != AGE_LIM) begin
            age <= age + 4'd1;
        end
    end

    // Address/data only move on a real write; x0 grants and idle cycles hold them
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we3 <= 1'b0;
            rf_a3  <= '0;
            rf_wd3 <= '0;
        end else if (clear_we) begin
            rf_we3 <= 1'b1;
            rf_a3  <= clear_addr;
            rf_wd3 <= '0;
        end else if (wr_en) begin
            rf_we3 <= 1'b1;
            rf_a3  <= sel_req.addr;
            rf_wd3 <= sel_req.data;
        end else begin
            rf_we3 <= 1'b0;
        end
    end

    assign init_done = clear_done;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// tb/tb_regfile_port_ctrl.sv - directed vector bench for regfile_port_ctrl
module tb_regfile_port_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        rf_we3;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3;
    logic        init_done;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        e_ar;
        logic        e_br;
        logic        e_we;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vecs[$];

    regfile_port_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .rf_we3    (rf_we3),
        .rf_a3     (rf_a3),
        .rf_wd3    (rf_wd3),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                           input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                           input logic e_ar, input logic e_br, input logic e_we,
                           input logic [4:0] e_a3, input logic [31:0] e_wd);
        vec_t v;
        v = '{av, aa, ad, bv, ba, bd, e_ar, e_br, e_we, e_a3, e_wd};
        vecs.push_back(v);
    endtask

    // Runs the 31-cycle clear; A keeps requesting until the final clear cycle
    task automatic run_clear(input string tag, input logic hold_a);
        for (int i = 1; i <= 31; i++) begin
            @(posedge clk);
            #1;
            a_valid = hold_a && (i < 31);
            b_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("%s_we_%0d", tag, i), 32'(rf_we3), 32'd1);
            chk($sformatf("%s_a3_%0d", tag, i), 32'(rf_a3), 32'(i));
            chk($sformatf("%s_wd_%0d", tag, i), rf_wd3, 32'd0);
            chk($sformatf("%s_done_%0d", tag, i), 32'(init_done), 32'(i == 31));
            chk($sformatf("%s_ard_%0d", tag, i), 32'(a_ready), 32'(i == 31));
            chk($sformatf("%s_brd_%0d", tag, i), 32'(b_ready), 32'(i == 31));
        end
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_post_we"}, 32'(rf_we3), 32'd0);
        chk({tag, "_post_done"}, 32'(init_done), 32'd1);
    endtask

    initial begin
        reset   = 1'b1;
        a_valid = 1'b0;
        a_addr  = '0;
        a_data  = '0;
        b_valid = 1'b0;
        b_addr  = '0;
        b_data  = '0;

        // single A write, then hold
        add_vec(1, 5, 32'hDEADBEEF, 0, 0, 0,  1, 0, 0, 31, 32'h0);
        add_vec(0, 0, 0,            0, 0, 0,  1, 1, 1, 5,  32'hDEADBEEF);
        add_vec(0, 0, 0,            0, 0, 0,  1, 1, 0, 5,  32'hDEADBEEF);
        // both continuously valid: A,A,A,A,B twice
        add_vec(1, 3, 32'hA3, 1, 7, 32'hB7,  1, 0, 0, 5, 32'hDEADBEEF);
        add_vec(1, 3, 32'hA3, 1, 7, 32'hB7,  1, 0, 1, 3, 32'hA3);
        add_vec(1, 3, 32'hA3, 1, 7, 32'hB7,  1, 0, 1, 3, 32'hA3);
        add_vec(1, 3, 32'hA3, 1, 7, 32'hB7,  1, 0, 1, 3, 32'hA3);
        add_vec(1, 3, 32'hA3, 1, 7, 32'hB7,  0, 1, 1, 3, 32'hA3);
        add_vec(1, 3, 32'hA3, 1, 7, 32'hB7,  1, 0, 1, 7, 32'hB7);
        add_vec(1, 3, 32'hA3, 1, 7, 32'hB7,  1, 0, 1, 3, 32'hA3);
        add_vec(1, 3, 32'hA3, 1, 7, 32'hB7,  1, 0, 1, 3, 32'hA3);
        add_vec(1, 3, 32'hA3, 1, 7, 32'hB7,  1, 0, 1, 3, 32'hA3);
        add_vec(1, 3, 32'hA3, 1, 7, 32'hB7,  0, 1, 1, 3, 32'hA3);
        add_vec(1, 3, 32'hA3, 1, 7, 32'hB7,  1, 0, 1, 7, 32'hB7);
        // B stalls 3 cycles, drops for one, then needs 4 fresh stalls
        add_vec(0, 0, 0,      0, 0, 0,       1, 1, 1, 3, 32'hA3);
        add_vec(1, 3, 32'hA3, 1, 7, 32'hB7,  1, 0, 0, 3, 32'hA3);
        add_vec(1, 3, 32'hA3, 1, 7, 32'hB7,  1, 0, 1, 3, 32'hA3);
        add_vec(1, 3, 32'hA3, 1, 7, 32'hB7,  1, 0, 1, 3, 32'hA3);
        add_vec(1, 3, 32'hA3, 0, 0, 0,       1, 0, 1, 3, 32'hA3);
        add_vec(1, 3, 32'hA3, 1, 7, 32'hB7,  1, 0, 1, 3, 32'hA3);
        add_vec(1, 3, 32'hA3, 1, 7, 32'hB7,  1, 0, 1, 3, 32'hA3);
        add_vec(1, 3, 32'hA3, 1, 7, 32'hB7,  1, 0, 1, 3, 32'hA3);
        add_vec(1, 3, 32'hA3, 1, 7, 32'hB7,  1, 0, 1, 3, 32'hA3);
        add_vec(1, 3, 32'hA3, 1, 7, 32'hB7,  0, 1, 1, 3, 32'hA3);
        add_vec(0, 0, 0,      0, 0, 0,       1, 1, 1, 7, 32'hB7);
        // B writes x0: handshake completes, no write, age cleared
        add_vec(0, 0, 0,      1, 0, 32'h12345678, 1, 1, 0, 7, 32'hB7);
        add_vec(1, 3, 32'hA3, 1, 7, 32'hB7,  1, 0, 0, 7, 32'hB7);
        add_vec(1, 3, 32'hA3, 1, 7, 32'hB7,  1, 0, 1, 3, 32'hA3);
        // A writes x0
        add_vec(1, 0, 32'hFFFF, 0, 0, 0,     1, 0, 1, 3, 32'hA3);
        add_vec(0, 0, 0,      0, 0, 0,       1, 1, 0, 3, 32'hA3);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 32'(rf_we3), 32'd0);
        chk("rst_a3", 32'(rf_a3), 32'd0);
        chk("rst_wd", rf_wd3, 32'd0);
        chk("rst_done", 32'(init_done), 32'd0);
        chk("rst_ard", 32'(a_ready), 32'd0);
        chk("rst_brd", 32'(b_ready), 32'd0);
        reset   = 1'b0;
        a_valid = 1'b1;
        a_addr  = 5'd9;
        a_data  = 32'h99;

        run_clear("clr", 1'b1);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            a_valid = vecs[i].av;
            a_addr  = vecs[i].aa;
            a_data  = vecs[i].ad;
            b_valid = vecs[i].bv;
            b_addr  = vecs[i].ba;
            b_data  = vecs[i].bd;
            @(negedge clk);
            chk($sformatf("v%0d_ard", i), 32'(a_ready), 32'(vecs[i].e_ar));
            chk($sformatf("v%0d_brd", i), 32'(b_ready), 32'(vecs[i].e_br));
            chk($sformatf("v%0d_we", i),  32'(rf_we3),  32'(vecs[i].e_we));
            chk($sformatf("v%0d_a3", i),  32'(rf_a3),   32'(vecs[i].e_a3));
            chk($sformatf("v%0d_wd", i),  rf_wd3,       vecs[i].e_wd);
        end

        // reset in RUN with A pending: the grant in the reset cycle is dropped
        @(posedge clk);
        #1;
        reset   = 1'b1;
        a_valid = 1'b1;
        a_addr  = 5'd9;
        a_data  = 32'h99;
        b_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_we", 32'(rf_we3), 32'd0);
        chk("mid_rst_done", 32'(init_done), 32'd0);
        chk("mid_rst_ard", 32'(a_ready), 32'd0);
        reset = 1'b0;

        run_clear("reclr", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_port_ctrl.md
Name: regfile_port_ctrl

Overview:
- Controller for the 32x32 register file write port (A3/WD3/WE3).
- After reset, sequences a clear of x1..x31 through the write port, so the register file itself needs no bulk reset loop.
- In normal operation, arbitrates the single write port between two writeback requesters using valid/ready handshakes:
  - A: single-cycle ALU/load writeback, high priority.
  - B: multi-cycle unit (mul/div), aged priority.
- Sits between the writeback stage and Register_File; drives its WE3/A3/WD3 inputs.

Parameters:
- XLEN, 32, data width of register write data.
- AW, 5, register address width.
- NREG, 32, number of architectural registers (2**AW).
- AGE_MAX, 4, consecutive stalled B cycles after which B wins the next arbitration; range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- a_valid  in  1  requester A has a write.
- a_ready  out  1  A write accepted this cycle when a_valid & a_ready.
- a_addr  in  AW  destination register of A.
- a_data  in  XLEN  write data of A.
- b_valid  in  1  requester B has a write.
- b_ready  out  1  B write accepted this cycle when b_valid & b_ready.
- b_addr  in  AW  destination register of B.
- b_data  in  XLEN  write data of B.
- rf_we3  out  1  register file write enable (registered).
- rf_a3  out  AW  register file write address (registered).
- rf_wd3  out  XLEN  register file write data (registered).
- init_done  out  1  high once the clear sequence has completed (registered).

Behaviour:
- Clocking and reset:
  - Single clock `clk`; reset `reset` is synchronous, active-high.
  - Reset values: state=CLEAR, clr_idx=1, age=0, rf_we3=0, rf_a3=0, rf_wd3=0, init_done=0.
- States: CLEAR and RUN.
- CLEAR:
  - a_ready=b_ready=0.
  - Each cycle registers rf_we3=1, rf_a3=clr_idx, rf_wd3=0, then clr_idx++.
  - When clr_idx==NREG-1 is issued, next state is RUN and init_done is set to 1 at the same edge.
  - Result: rf_we3 is high for exactly 31 consecutive cycles, addresses 1..31 in order; x0 is never written.
- RUN, ready logic (combinational from state, age, a_valid):
  - force_b = (age==AGE_MAX) & b_valid.
  - a_ready = !force_b.
  - b_ready = force_b | !a_valid.
- RUN, grant rules:
  - When both are valid and age<AGE_MAX, A is granted.
  - At most one grant per cycle, guaranteed by construction.
- RUN, write latency:
  - A grant at edge N gives rf_we3=1 with the granted addr/data during cycle N+1. The register file captures the write at the end of cycle N+1.
  - With no grant, rf_we3=0; rf_a3/rf_wd3 hold their previous values.
- x0 writes:
  - A grant with addr==0 still completes the handshake and still counts for aging.
  - rf_we3 stays 0 for that grant.
- Age counter (4-bit):
  - Increments when b_valid & !b_ready, saturating at AGE_MAX.
  - Clears to 0 on a B grant or whenever b_valid==0.
- Reset asserted mid-RUN:
  - Any grant in the reset cycle is discarded.
  - rf_we3=0 at the next edge; the clear sequence restarts at clr_idx=1; init_done drops to 0.
  - Requesters must re-issue anything not yet written.
- Requester contract:
  - Requesters hold valid/addr/data stable until accepted.
  - The controller does not check this contract.
- No address conflict checks: writes are strictly serialized in grant order.

Decomposition:
- Package regfile_ctrl_pkg:
  - XLEN, AW, NREG, AGE_MAX defaults.
  - State enum rf_ctrl_state_t {CLEAR, RUN}.
  - Struct rf_wr_t {addr, data} used by both requesters.
- One natural sub-module: rf_clear_seq.
  - Holds clr_idx and the CLEAR-to-RUN completion flag.
  - Outputs clear_we/clear_addr/clear_done.
  - Muxed with the arbiter output in front of the rf_* flops.

Test Plan:
- Reset 2 cycles, then release → rf_we3 high exactly 31 cycles, rf_a3 = 1,2,...,31, rf_wd3=0; init_done=1 from the cycle after the last clear write; a_ready=b_ready=0 throughout CLEAR.
- RUN, a_valid=1, a_addr=5, a_data=32'hDEADBEEF for one cycle → a_ready=1; next cycle rf_we3=1, rf_a3=5, rf_wd3=32'hDEADBEEF; the following cycle rf_we3=0.
- RUN, A and B both valid continuously (A addr 3, B addr 7), AGE_MAX=4 → grant pattern A,A,A,A,B repeats; rf_a3 sequence 3,3,3,3,7,...
- B valid 3 stalled cycles, b_valid dropped 1 cycle, then reasserted alongside A → age restarts at 0; B is granted only after 4 further stalled cycles.
- b_valid=1, b_addr=0, b_data=32'h12345678, A idle → b_ready=1, rf_we3 stays 0, age=0.
- Reset asserted in RUN while a_valid=1 (a_addr=9) → next cycle rf_we3=0 and init_done=0; after release, the clear sequence restarts at rf_a3=1 and no write to address 9 occurs.
